seg_scan_ctrl: RTL



---
 rtl/seg_scan_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a common-anode
// 7-segment bank. Display data is double-buffered and only swapped in at
// the end of a scan frame, so a value change never shows torn digits.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lzb,
    output logic [3:0]              hex,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    dp_n,
    output logic                    frame_done,
    output logic                    pending
);

    localparam int DW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [DW-1:0]             div_cnt;
    logic [IW-1:0]             idx;
    logic [4*NUM_DIGITS-1:0]   disp_data;
    logic [NUM_DIGITS-1:0]     disp_dp;
    logic [4*NUM_DIGITS-1:0]   pend_data;
    logic [NUM_DIGITS-1:0]     pend_dp;

    logic                      tick;
    logic                      wrap;
    logic [NUM_DIGITS-1:0]     blank_vec;
    logic                      blank_cur;
    logic [3:0]                cur_nib;
    logic                      cur_dp;
    logic [NUM_DIGITS-1:0]     an_next;

    assign tick = (div_cnt == DIV_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    // Refresh divider: one tick per digit slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    // Digit index: advances on tick, wraps at the last digit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else if (tick) begin
            if (idx == IDX_LAST) begin
                idx <= '0;
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

    // Double buffer: loads park in pend_*, commit to disp_* at frame wrap;
    // a load coinciding with wrap bypasses the pending stage so it still wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_data <= '0;
            disp_dp   <= '0;
            pend_data <= '0;
            pend_dp   <= '0;
            pending   <= 1'b0;
        end else if (wrap) begin
            if (load) begin
                disp_data <= data_in;
                disp_dp   <= dp_in;
                pending   <= 1'b0;
            end else if (pending) begin
                disp_data <= pend_data;
                disp_dp   <= pend_dp;
                pending   <= 1'b0;
            end
        end else if (load) begin
            pend_data <= data_in;
            pend_dp   <= dp_in;
            pending   <= 1'b1;
        end
    end

    // Per-digit blanking: disabled digits, plus leading zeros when lzb is set
    // (scanned from the most significant digit down, digit 0 always exempt)
    always_comb begin
        logic        run_zero;
        int unsigned j;
        run_zero  = 1'b1;
        j         = 0;
        blank_vec = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            j         = NUM_DIGITS - 1 - k;
            run_zero  = run_zero & (disp_data[j*4 +: 4] == 4'h0);
            blank_vec[j] = ~digit_en[j] | (lzb & run_zero & (j != 0));
        end
    end

    // Current-digit selects feeding the output registers
    always_comb begin
        cur_nib   = disp_data[{idx, 2'b00} +: 4];
        cur_dp    = disp_dp[idx];
        blank_cur = blank_vec[idx];
        an_next   = '1;
        if (!blank_cur) begin
            an_next[idx] = 1'b0;
        end
    end

    // Registered outputs, one cycle behind idx
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hex        <= '0;
            an         <= '1;
            dp_n       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            hex        <= cur_nib;
            an         <= an_next;
            dp_n       <= blank_cur ? 1'b1 : ~cur_dp;
            frame_done <= wrap;
        end
    end

endmodule
